// File: rtl/rn_req_buffer_if.sv
// Requester-side bus bundle for rn_req_buffer: request in, crossbar-facing request/select,
// and the response path back to the requester.
interface rn_req_buffer_if #(
  parameter int REQ_W = 16,
  parameter int RSP_W = 8,
  parameter int CNT_W = 3
);
  logic [REQ_W-1:0] req_in;
  logic             req_ready;
  logic [REQ_W-1:0] bf_out;
  logic [2:0]       sel;
  logic [RSP_W-1:0] reqr_rsp;
  logic [RSP_W-1:0] rsp_out;
  logic             timeout_err;
  logic [CNT_W-1:0] fifo_count;

  modport slave (
    input  req_in, reqr_rsp,
    output req_ready, bf_out, sel, rsp_out, timeout_err, fifo_count
  );

  modport master (
    output req_in, reqr_rsp,
    input  req_ready, bf_out, sel, rsp_out, timeout_err, fifo_count
  );
endinterface

// File: rtl/rn_req_buffer.sv
// Request FIFO plus single-outstanding dispatcher in front of rn_crossbar: holds sel
// while waiting so the response routes back, aborts with a pulse on timeout.
`ifndef REQ_FLIT_WIDTH
`define REQ_FLIT_WIDTH 16
`endif
`ifndef RSP_FLIT_WIDTH
`define RSP_FLIT_WIDTH 8
`endif

module rn_req_buffer #(
  parameter int REQ_FLIT_WIDTH = `REQ_FLIT_WIDTH,
  parameter int RSP_FLIT_WIDTH = `RSP_FLIT_WIDTH,
  parameter int DEPTH          = 4,
  parameter int TGT_LSB        = 1,
  parameter int TIMEOUT        = 16
) (
  input logic            clk,
  input logic            rst,
  rn_req_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_RSP} state_t;

  state_t                    state, state_nx;
  logic [REQ_FLIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count;
  logic                      push, pop;
  logic [REQ_FLIT_WIDTH-1:0] head;
  logic [1:0]                tgt;

  logic [REQ_FLIT_WIDTH-1:0] bf_q, bf_nx;
  logic [2:0]                sel_q, sel_nx;
  logic [RSP_FLIT_WIDTH-1:0] rsp_q, rsp_nx;
  logic                      err_q, err_nx;
  logic [TW-1:0]             tcnt, tcnt_nx;

  // Ready is judged on pre-dequeue occupancy, so a full FIFO cannot take a flit even
  // in the cycle it pops.
  assign bus.req_ready  = (count != CW'(DEPTH));
  assign push           = bus.req_in[0] && bus.req_ready;
  assign pop            = (state == IDLE) && (count != '0);
  assign head           = mem[rd_ptr];
  assign tgt            = head[TGT_LSB+1:TGT_LSB];

  assign bus.bf_out      = bf_q;
  assign bus.sel         = sel_q;
  assign bus.rsp_out     = rsp_q;
  assign bus.timeout_err = err_q;
  assign bus.fifo_count  = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.req_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bf_q  <= '0;
      sel_q <= '0;
      rsp_q <= '0;
      err_q <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      bf_q  <= bf_nx;
      sel_q <= sel_nx;
      rsp_q <= rsp_nx;
      err_q <= err_nx;
      tcnt  <= tcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    bf_nx    = '0;
    sel_nx   = sel_q;
    rsp_nx   = '0;
    err_nx   = 1'b0;
    tcnt_nx  = tcnt;
    case (state)
      IDLE: begin
        sel_nx = '0;
        if (pop) begin
          bf_nx    = head;
          sel_nx   = {1'b0, tgt} + 3'd1;
          state_nx = DISPATCH;
        end
      end
      DISPATCH: begin
        tcnt_nx  = '0;
        state_nx = WAIT_RSP;
      end
      WAIT_RSP: begin
        tcnt_nx = tcnt + TW'(1);
        // A response in the final cycle beats the timeout.
        if (bus.reqr_rsp[0]) begin
          rsp_nx   = bus.reqr_rsp;
          sel_nx   = '0;
          state_nx = IDLE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_nx   = 1'b1;
          sel_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        sel_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_rn_req_buffer.sv
// Directed bench for rn_req_buffer: per-cycle vector table plus timeout, coincident
// response and asynchronous reset sequences.
module tb_rn_req_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  rn_req_buffer_if #(.REQ_W(16), .RSP_W(8), .CNT_W(3)) bus ();

  rn_req_buffer #(
    .REQ_FLIT_WIDTH(16), .RSP_FLIT_WIDTH(8), .DEPTH(4), .TGT_LSB(1), .TIMEOUT(16)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] req;
    logic [7:0]  rsp;
    logic [15:0] bf;
    logic [2:0]  sel;
    logic [7:0]  ro;
    logic        err;
    logic [2:0]  cnt;
    logic        rdy;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic [15:0] req, input logic [7:0] rsp,
                              input logic [15:0] bf, input logic [2:0] sel,
                              input logic [7:0] ro, input logic err,
                              input logic [2:0] cnt, input logic rdy);
    vec_t v;
    v.req = req; v.rsp = rsp; v.bf = bf; v.sel = sel;
    v.ro = ro; v.err = err; v.cnt = cnt; v.rdy = rdy;
    vt.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [15:0] bf, input logic [2:0] sel,
                         input logic [7:0] ro, input logic err, input logic [2:0] cnt,
                         input logic rdy);
    chk({nm, ".bf_out"},      32'(bus.bf_out),      32'(bf));
    chk({nm, ".sel"},         32'(bus.sel),         32'(sel));
    chk({nm, ".rsp_out"},     32'(bus.rsp_out),     32'(ro));
    chk({nm, ".timeout_err"}, 32'(bus.timeout_err), 32'(err));
    chk({nm, ".fifo_count"},  32'(bus.fifo_count),  32'(cnt));
    chk({nm, ".req_ready"},   32'(bus.req_ready),   32'(rdy));
  endtask

  task automatic step(input logic [15:0] r, input logic [7:0] s);
    bus.req_in   = r;
    bus.reqr_rsp = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_in   = '0;
    bus.reqr_rsp = '0;

    // single request to target 2, then a response ignored in IDLE
    add(16'h2203, 8'h00, 16'h0000, 3'd0, 8'h00, 0, 3'd1, 1);
    add(16'h0000, 8'h00, 16'h2203, 3'd2, 8'h00, 0, 3'd0, 1);
    add(16'h0000, 8'h00, 16'h0000, 3'd2, 8'h00, 0, 3'd0, 1);
    add(16'h0000, 8'h00, 16'h0000, 3'd2, 8'h00, 0, 3'd0, 1);
    add(16'h0000, 8'hA5, 16'h0000, 3'd0, 8'hA5, 0, 3'd0, 1);
    add(16'h0000, 8'h33, 16'h0000, 3'd0, 8'h00, 0, 3'd0, 1);
    add(16'h0000, 8'h00, 16'h0000, 3'd0, 8'h00, 0, 3'd0, 1);
    // fill: 5 accepted (one dispatched), 6th dropped, then in-order drain
    add(16'h1101, 8'h00, 16'h0000, 3'd0, 8'h00, 0, 3'd1, 1);
    add(16'h2203, 8'h00, 16'h1101, 3'd1, 8'h00, 0, 3'd1, 1);
    add(16'h3305, 8'h00, 16'h0000, 3'd1, 8'h00, 0, 3'd2, 1);
    add(16'h4407, 8'h00, 16'h0000, 3'd1, 8'h00, 0, 3'd3, 1);
    add(16'h5501, 8'h00, 16'h0000, 3'd1, 8'h00, 0, 3'd4, 0);
    add(16'h6601, 8'h00, 16'h0000, 3'd1, 8'h00, 0, 3'd4, 0);
    add(16'h0000, 8'h11, 16'h0000, 3'd0, 8'h11, 0, 3'd4, 0);
    add(16'h0000, 8'h00, 16'h2203, 3'd2, 8'h00, 0, 3'd3, 1);
    add(16'h0000, 8'h00, 16'h0000, 3'd2, 8'h00, 0, 3'd3, 1);
    add(16'h0000, 8'h23, 16'h0000, 3'd0, 8'h23, 0, 3'd3, 1);
    add(16'h0000, 8'h00, 16'h3305, 3'd3, 8'h00, 0, 3'd2, 1);
    add(16'h0000, 8'h45, 16'h0000, 3'd3, 8'h00, 0, 3'd2, 1);
    add(16'h0000, 8'h37, 16'h0000, 3'd0, 8'h37, 0, 3'd2, 1);
    add(16'h0000, 8'h00, 16'h4407, 3'd4, 8'h00, 0, 3'd1, 1);
    add(16'h0000, 8'h00, 16'h0000, 3'd4, 8'h00, 0, 3'd1, 1);
    add(16'h0000, 8'h49, 16'h0000, 3'd0, 8'h49, 0, 3'd1, 1);
    add(16'h0000, 8'h00, 16'h5501, 3'd1, 8'h00, 0, 3'd0, 1);
    add(16'h0000, 8'h00, 16'h0000, 3'd1, 8'h00, 0, 3'd0, 1);
    add(16'h0000, 8'h51, 16'h0000, 3'd0, 8'h51, 0, 3'd0, 1);
    add(16'h0000, 8'h00, 16'h0000, 3'd0, 8'h00, 0, 3'd0, 1);

    // reset state, sampled between edges
    #2;
    chk_all("reset", 16'h0, 3'd0, 8'h0, 0, 3'd0, 1);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("idle", 16'h0, 3'd0, 8'h0, 0, 3'd0, 1);

    foreach (vt[i]) begin
      step(vt[i].req, vt[i].rsp);
      chk_all($sformatf("vec%0d", i), vt[i].bf, vt[i].sel, vt[i].ro, vt[i].err,
              vt[i].cnt, vt[i].rdy);
    end

    // timeout after 16 WAIT_RSP cycles, then next queued request dispatches
    step(16'h7705, 8'h00); chk("to.cnt", 32'(bus.fifo_count), 32'd1);
    step(16'h8801, 8'h00); chk_all("to.disp", 16'h7705, 3'd3, 8'h0, 0, 3'd1, 1);
    step(16'h0000, 8'h00); chk_all("to.wait", 16'h0, 3'd3, 8'h0, 0, 3'd1, 1);
    for (int n = 1; n < 16; n++) begin
      step(16'h0000, 8'h00);
      chk($sformatf("to.err%0d", n), 32'(bus.timeout_err), 32'd0);
      chk($sformatf("to.sel%0d", n), 32'(bus.sel), 32'd3);
    end
    step(16'h0000, 8'h00); chk_all("to.abort", 16'h0, 3'd0, 8'h0, 1, 3'd1, 1);
    step(16'h0000, 8'h00); chk_all("to.next", 16'h8801, 3'd1, 8'h0, 0, 3'd0, 1);
    step(16'h0000, 8'h00); chk_all("co.wait", 16'h0, 3'd1, 8'h0, 0, 3'd0, 1);

    // response in the final WAIT_RSP cycle wins over timeout
    for (int n = 1; n < 16; n++) begin
      step(16'h0000, 8'h00);
      chk($sformatf("co.err%0d", n), 32'(bus.timeout_err), 32'd0);
    end
    step(16'h0000, 8'h9B); chk_all("co.rsp", 16'h0, 3'd0, 8'h9B, 0, 3'd0, 1);
    step(16'h0000, 8'h00); chk_all("co.after", 16'h0, 3'd0, 8'h0, 0, 3'd0, 1);

    // async reset mid-WAIT_RSP with two entries queued
    step(16'hC103, 8'h00);
    step(16'hD205, 8'h00); chk_all("rs.disp", 16'hC103, 3'd2, 8'h0, 0, 3'd1, 1);
    step(16'hE307, 8'h00);
    step(16'h0000, 8'h00); chk_all("rs.wait", 16'h0, 3'd2, 8'h0, 0, 3'd2, 1);
    #2 rst = 1'b1;
    #1 chk_all("rs.async", 16'h0, 3'd0, 8'h0, 0, 3'd0, 1);
    #2 rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step(16'h0000, 8'h00);
      chk_all($sformatf("rs.quiet%0d", n), 16'h0, 3'd0, 8'h0, 0, 3'd0, 1);
    end
    step(16'hF101, 8'h00); chk_all("rs.push", 16'h0, 3'd0, 8'h0, 0, 3'd1, 1);
    step(16'h0000, 8'h00); chk_all("rs.disp2", 16'hF101, 3'd1, 8'h0, 0, 3'd0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
